// File: rtl/scpu_inst_reloader.sv
// rtl/scpu_inst_reloader.sv - reloads the serial CPU instruction window from a word stream
module scpu_inst_reloader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_PC    = 250,
    parameter int MAX_WORDS  = 8,
    localparam int CNT_W     = $clog2(MAX_WORDS) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            nxt,
    input  logic                  inst_valid,
    input  logic [15:0]           inst_data,
    input  logic                  inst_last,
    output logic                  inst_ready,
    output logic                  ld_own,
    output logic [ADDR_WIDTH-1:0] ld_addr,
    output logic                  ld_we,
    output logic [7:0]            ld_data,
    output logic                  start,
    output logic                  cpu_halt,
    output logic                  overflow,
    output logic [CNT_W-1:0]      word_cnt
);

    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(BASE_PC * 2);
    localparam logic [CNT_W-1:0]      MAX_CNT   = CNT_W'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WR_LO,
        WR_HI,
        KICK,
        HALTED
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic                    nxt1_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [15:0]             word_q;
    logic                    last_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ovf_q;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    req;

    // Only a rising edge of the reload line counts, so a level held over a burst cannot retrigger it
    assign req     = nxt[1] & ~nxt1_q;
    assign cnt_inc = cnt_q + CNT_W'(1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; halt has priority over a simultaneous reload request
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (nxt[0]) begin
                    state_n = HALTED;
                end else if (req) begin
                    state_n = ACCEPT;
                end
            end
            ACCEPT: begin
                if (inst_valid) begin
                    state_n = WR_LO;
                end
            end
            WR_LO:  state_n = WR_HI;
            WR_HI: begin
                if (last_q || (cnt_inc == MAX_CNT)) begin
                    state_n = KICK;
                end else begin
                    state_n = ACCEPT;
                end
            end
            KICK:   state_n = IDLE;
            HALTED: state_n = HALTED;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: edge register, word capture, byte address and burst bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt1_q <= 1'b0;
            addr_q <= '0;
            word_q <= '0;
            last_q <= 1'b0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            nxt1_q <= nxt[1];
            case (state)
                IDLE: begin
                    if (!nxt[0] && req) begin
                        addr_q <= BASE_ADDR;
                        cnt_q  <= '0;
                        ovf_q  <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (inst_valid) begin
                        word_q <= inst_data;
                        last_q <= inst_last;
                    end
                end
                WR_LO: begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                end
                WR_HI: begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    cnt_q  <= cnt_inc;
                    if (!last_q && (cnt_inc == MAX_CNT)) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state so an async reset drops the write strobe and port ownership at once
    always_comb begin
        inst_ready = 1'b0;
        ld_own     = 1'b0;
        ld_we      = 1'b0;
        ld_data    = 8'h00;
        start      = 1'b0;
        cpu_halt   = 1'b0;
        case (state)
            ACCEPT: begin
                inst_ready = 1'b1;
                ld_own     = 1'b1;
            end
            WR_LO: begin
                ld_own  = 1'b1;
                ld_we   = 1'b1;
                ld_data = word_q[7:0];
            end
            WR_HI: begin
                ld_own  = 1'b1;
                ld_we   = 1'b1;
                ld_data = word_q[15:8];
            end
            KICK:   start    = 1'b1;
            HALTED: cpu_halt = 1'b1;
            default: ;
        endcase
    end

    assign ld_addr  = addr_q;
    assign overflow = ovf_q;
    assign word_cnt = cnt_q;

endmodule
